// File: rtl/mul_add_seq_ctrl.sv
// Sequencing controller for a repeated-addition multiplier (A, B, P registers and A+P adder).
// Loads A then B over a shared handshaked bus, accumulates until B == 0, with limit and abort exits.
module mul_add_seq_ctrl #(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             eqz,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             ld_p,
  output logic             dec_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StCheck,
    StAcc,
    StDone,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    op_ready = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    clr_p    = 1'b0;
    ld_p     = 1'b0;
    dec_b    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state_q != StIdle);

    // Abort wins over every other exit and silences all strobes; the counter holds.
    if (busy && abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoadA;
            iter_d  = '0;
          end
        end
        StLoadA: begin
          clr_p    = 1'b1;
          op_ready = 1'b1;
          if (op_valid) begin
            ld_a    = 1'b1;
            state_d = StLoadB;
          end
        end
        StLoadB: begin
          op_ready = 1'b1;
          if (op_valid) begin
            ld_b    = 1'b1;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (eqz) begin
            state_d = StDone;
          end else if (iter_q == MAX_ITER) begin
            state_d = StErr;
          end else begin
            state_d = StAcc;
          end
        end
        StAcc: begin
          ld_p    = 1'b1;
          dec_b   = 1'b1;
          iter_d  = iter_q + CNT_W'(1);
          state_d = StCheck;
        end
        StDone: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        StErr: begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_mul_add_seq_ctrl.sv
// Bench for mul_add_seq_ctrl: closes the loop with a small A/B/P datapath and checks every
// cycle's strobes against a timeline computed from operand values, stalls and abort/reset points.
module tb_mul_add_seq_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int          LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, err;
  logic             eqz;
  logic [CNT_W-1:0] iter_cnt;
  logic [14:0]      bus = '0;
  logic [14:0]      dp_a = '0, dp_b = '0, dp_p = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_add_seq_ctrl #(
    .CNT_W   (CNT_W),
    .MAX_ITER(CNT_W'(LIMIT))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .eqz     (eqz),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .clr_p   (clr_p),
    .ld_p    (ld_p),
    .dec_b   (dec_b),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .iter_cnt(iter_cnt)
  );

  // Datapath the controller steers.
  assign eqz = (dp_b == 15'd0);
  always @(posedge clk) begin
    if (ld_a)  dp_a <= bus;
    if (ld_b)  dp_b <= bus;
    else if (dec_b) dp_b <= dp_b - 15'd1;
    if (clr_p) dp_p <= '0;
    else if (ld_p) dp_p <= dp_p + dp_a;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {busy,op_ready,ld_a,ld_b,clr_p,ld_p,dec_b,done,err} in cycle c after start.
  // Timeline: load A over sa+1 cycles, load B over sb+1 cycles, then CHECK/ACC pairs n times,
  // a final CHECK, and the done (or err) cycle.
  function automatic logic [8:0] exp_vec(input int c, input int sa, input int s, input int n,
                                         input bit e, input int kill, input bit kill_rst);
    int d;
    logic [8:0] v;
    d = s + 4 + 2 * n;
    v = '0;
    if (kill != 0 && c > kill) return '0;
    if (kill != 0 && !kill_rst && c == kill) return 9'h100;
    if (c < 1 || c > d) return '0;
    v[8] = 1'b1;
    if (c <= sa + 1) begin
      v[7] = 1'b1; v[4] = 1'b1; v[6] = (c == sa + 1);
    end else if (c <= s + 2) begin
      v[7] = 1'b1; v[5] = (c == s + 2);
    end else if (c == d) begin
      v[1] = 1'b1; v[0] = e;
    end else if (((c - s - 3) % 2) == 1) begin
      v[3] = 1'b1; v[2] = 1'b1;
    end
    return v;
  endfunction

  task automatic run_op(input logic [14:0] a, input logic [14:0] b, input int sa, input int sb,
                        input int kill, input bit kill_rst, input bit chained,
                        input bit start_next, input string name);
    int s, n, d, last, accs;
    bit e;
    logic [8:0] ev, ov;
    logic [CNT_W-1:0] exp_it;
    s    = sa + sb;
    e    = (int'(b) > LIMIT);
    n    = e ? LIMIT : int'(b);
    d    = s + 4 + 2 * n;
    last = (kill != 0) ? kill + 1 : d + 1;
    if (!chained) begin
      @(negedge clk);
      start    = 1'b1;
      abort    = 1'($urandom);
      op_valid = 1'($urandom);
      bus      = 15'($urandom);
      #1;
      ov = {busy, op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, done, err};
      checks++;
      if (ov !== 9'h000) begin
        errors++;
        $display("FAIL %s idle_outputs: got %b expected %b", name, ov, 9'h000);
      end
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = (c == last) ? start_next : 1'($urandom);
      abort = (c == last) ? 1'($urandom) : (kill != 0 && !kill_rst && c == kill);
      rst   = !(kill_rst && c == kill);
      if (c <= sa + 1) begin
        op_valid = (c == sa + 1); bus = a;
      end else if (c <= s + 2) begin
        op_valid = (c == s + 2); bus = b;
      end else begin
        op_valid = 1'($urandom); bus = 15'($urandom);
      end
      #1;
      ev = exp_vec(c, sa, s, n, e, kill, kill_rst);
      ov = {busy, op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, done, err};
      checks++;
      if (ov !== ev) begin
        errors++;
        $display("FAIL %s strobes cycle %0d: got %b expected %b", name, c, ov, ev);
      end
    end
    if (kill != 0 && kill_rst) begin
      exp_it = '0;
    end else if (kill != 0) begin
      accs = 0;
      for (int k = 0; k < n; k++) if (s + 4 + 2 * k < kill) accs++;
      exp_it = CNT_W'(accs);
    end else begin
      exp_it = CNT_W'(n);
    end
    checks++;
    if (iter_cnt !== exp_it) begin
      errors++;
      $display("FAIL %s iter_cnt: got %0d expected %0d", name, iter_cnt, exp_it);
    end
    if (kill == 0) begin
      checks++;
      if (dp_p !== 15'(int'(a) * n)) begin
        errors++;
        $display("FAIL %s product: got %0d expected %0d", name, dp_p, 15'(int'(a) * n));
      end
      checks++;
      if (dp_b !== 15'(int'(b) - n)) begin
        errors++;
        $display("FAIL %s b_residue: got %0d expected %0d", name, dp_b, 15'(int'(b) - n));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({busy, op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, done, err, iter_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_state: got busy=%b strobes=%b iter=%0d expected all 0", busy,
                 {op_ready, ld_a, ld_b, clr_p, ld_p, dec_b, done, err}, iter_cnt);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_basic();
    run_op(15'd3, 15'd4, 0, 0, 0, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_zero();
    run_op(15'd7, 15'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "b_zero");
  endtask

  task automatic test_stall();
    run_op(15'd2, 15'd2, 3, 2, 0, 1'b0, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_limit();
    run_op(15'd1, 15'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0, "limit");
  endtask

  task automatic test_abort();
    run_op(15'd5, 15'd6, 0, 0, 6, 1'b0, 1'b0, 1'b0, "abort");
    run_op(15'd5, 15'd3, 0, 0, 0, 1'b0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    run_op(15'd9, 15'd3, 1, 0, 4, 1'b1, 1'b0, 1'b0, "reset_mid");
    run_op(15'd9, 15'd3, 0, 0, 0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(15'd11, 15'd2, 0, 0, 0, 1'b0, 1'b0, 1'b1, "b2b_first");
    run_op(15'd13, 15'd3, 0, 1, 0, 1'b0, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    bit chain;
    chain = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [14:0] a, b;
      int sa, sb, n, kill;
      bit krst, nxt;
      a    = 15'($urandom);
      b    = 15'($urandom_range(0, 6));
      sa   = $urandom_range(0, 2);
      sb   = $urandom_range(0, 2);
      n    = (int'(b) > LIMIT) ? LIMIT : int'(b);
      kill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, sa + sb + 4 + 2 * n) : 0;
      krst = 1'($urandom);
      nxt  = 1'($urandom);
      run_op(a, b, sa, sb, kill, krst, chain, nxt, "random");
      chain = nxt;
    end
    if (chain) begin
      run_op(15'd1, 15'd1, 0, 0, 0, 1'b0, 1'b1, 1'b0, "random_tail");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_limit();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
